// File: rtl/mmio_pkg.sv
// Shared types and address decode for the data-side MMIO fabric.
// Decode takes the fabric parameters as arguments so one package serves every instance.
package mmio_pkg;

  typedef enum logic [2:0] {
    RAM  = 3'd0,
    CHAN = 3'd1,
    CNT  = 3'd2,
    STAT = 3'd3,
    NONE = 3'd4
  } region_e;

  typedef struct packed {
    region_e    region;
    logic [2:0] chan;
  } decode_t;

  localparam logic [3:0] OFF_CNT   = 4'hC;
  localparam logic [3:0] OFF_STAT  = 4'hE;
  localparam logic [3:0] OFF_ALIAS = 4'hF;

  // Offset 0xF aliases channel 0 so the legacy 0xFFFF display address keeps working.
  function automatic decode_t decode_addr(input logic [31:0] addr,
                                          input int unsigned data_addr_len,
                                          input logic [31:0] io_base,
                                          input int unsigned num_out);
    decode_t     d;
    logic [31:0] off;
    d.region = NONE;
    d.chan   = 3'd0;
    off      = addr - io_base;
    if (addr < (32'd1 << data_addr_len)) begin
      d.region = RAM;
    end else if (addr >= io_base && off < 32'd16) begin
      if (off < num_out) begin
        d.region = CHAN;
        d.chan   = off[2:0];
      end else if (off[3:0] == OFF_ALIAS) begin
        d.region = CHAN;
      end else if (off[3:0] == OFF_CNT) begin
        d.region = CNT;
      end else if (off[3:0] == OFF_STAT) begin
        d.region = STAT;
      end
    end
    return d;
  endfunction

endpackage

// File: rtl/mem_data.sv
// Single-port synchronous data RAM, read-first: a same-cycle write returns the old word.
module mem_data #(
  parameter int unsigned p_WORD_LEN      = 16,
  parameter int unsigned p_DATA_ADDR_LEN = 10
) (
  input  logic                       i_clk,
  input  logic                       i_wr_en,
  input  logic [p_DATA_ADDR_LEN-1:0] i_addr,
  input  logic [p_WORD_LEN-1:0]      i_wr_data,
  output logic [p_WORD_LEN-1:0]      o_rd_data
);

  logic [p_WORD_LEN-1:0] mem [0:(1 << p_DATA_ADDR_LEN)-1];

  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      mem[i_addr] <= i_wr_data;
    end
    o_rd_data <= mem[i_addr];
  end

endmodule

// File: rtl/mmio_fabric.sv
// Data-side bus fabric: RAM region, output channels with strobes and sticky flags,
// free-running cycle counter, and a registered one-cycle read return.
module mmio_fabric
  import mmio_pkg::*;
#(
  parameter int unsigned           p_WORD_LEN      = 16,
  parameter int unsigned           p_DATA_ADDR_LEN = 10,
  parameter int unsigned           p_NUM_OUT       = 4,
  parameter logic [p_WORD_LEN-1:0] p_IO_BASE       = 16'hFFF0
) (
  input  logic                                 i_clk,
  input  logic                                 i_rst,
  input  logic [p_WORD_LEN-1:0]                i_addr,
  input  logic                                 i_wr_en,
  input  logic [p_WORD_LEN-1:0]                i_wr_data,
  output logic [p_WORD_LEN-1:0]                o_rd_data,
  output logic [p_NUM_OUT-1:0][p_WORD_LEN-1:0] o_out,
  output logic [p_NUM_OUT-1:0]                 o_out_stb
);

  if (p_NUM_OUT < 1 || p_NUM_OUT > 8) begin : g_bad_num_out
    $error("mmio_fabric: p_NUM_OUT must be in 1..8");
  end
  if (p_IO_BASE[3:0] != 4'd0) begin : g_bad_io_align
    $error("mmio_fabric: p_IO_BASE must be 16-aligned");
  end
  if (32'(p_IO_BASE) < (32'd1 << p_DATA_ADDR_LEN)) begin : g_bad_io_overlap
    $error("mmio_fabric: IO window overlaps the RAM region");
  end

  decode_t               dec;
  logic [p_NUM_OUT-1:0]  chan_sel;
  logic [p_NUM_OUT-1:0]  chan_wr;
  logic [p_NUM_OUT-1:0]  status_q;
  logic [p_WORD_LEN-1:0] cnt_q;
  logic [p_WORD_LEN-1:0] io_word;
  logic [p_WORD_LEN-1:0] io_rd_q;
  logic [p_WORD_LEN-1:0] ram_rd;
  logic                  ram_wr;
  region_e               sel_q;

  always_comb begin
    dec      = decode_addr(32'(i_addr), p_DATA_ADDR_LEN, 32'(p_IO_BASE), p_NUM_OUT);
    chan_sel = '0;
    io_word  = '0;
    for (int k = 0; k < p_NUM_OUT; k++) begin
      chan_sel[k] = (dec.region == CHAN) && (dec.chan == 3'(k));
      if (chan_sel[k]) begin
        io_word = o_out[k];
      end
    end
    case (dec.region)
      CNT:     io_word = cnt_q;
      STAT:    io_word = p_WORD_LEN'(status_q);
      default: ;
    endcase
    chan_wr = i_wr_en ? chan_sel : '0;
    ram_wr  = i_wr_en && (dec.region == RAM);
  end

  mem_data #(
    .p_WORD_LEN      (p_WORD_LEN),
    .p_DATA_ADDR_LEN (p_DATA_ADDR_LEN)
  ) u_ram (
    .i_clk     (i_clk),
    .i_wr_en   (ram_wr),
    .i_addr    (i_addr[p_DATA_ADDR_LEN-1:0]),
    .i_wr_data (i_wr_data),
    .o_rd_data (ram_rd)
  );

  // The IO word is captured before this edge's write lands, so reads see the old value.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_out     <= '0;
      o_out_stb <= '0;
      status_q  <= '0;
      cnt_q     <= '0;
      io_rd_q   <= '0;
      sel_q     <= NONE;
    end else begin
      sel_q     <= dec.region;
      io_rd_q   <= io_word;
      o_out_stb <= chan_wr;
      for (int k = 0; k < p_NUM_OUT; k++) begin
        if (chan_wr[k]) begin
          o_out[k] <= i_wr_data;
        end
      end
      if (i_wr_en && dec.region == STAT) begin
        status_q <= status_q & ~i_wr_data[p_NUM_OUT-1:0];
      end else begin
        status_q <= status_q | chan_wr;
      end
      if (i_wr_en && dec.region == CNT) begin
        cnt_q <= i_wr_data;
      end else begin
        cnt_q <= cnt_q + p_WORD_LEN'(1);
      end
    end
  end

  always_comb begin
    case (sel_q)
      RAM:             o_rd_data = ram_rd;
      CHAN, CNT, STAT: o_rd_data = io_rd_q;
      default:         o_rd_data = '0;
    endcase
  end

endmodule

// File: tb/tb_mmio_fabric.sv
// Randomised and directed bench for mmio_fabric against a behavioural memory-map model.
module tb_mmio_fabric;

  localparam int NOUT = 4;

  logic                  clk;
  logic                  rst;
  logic [15:0]           addr;
  logic                  wr_en;
  logic [15:0]           wr_data;
  logic [15:0]           rd_data;
  logic [NOUT-1:0][15:0] out;
  logic [NOUT-1:0]       out_stb;

  int checks;
  int errors;

  logic [15:0]           m_ram [0:1023];
  logic [NOUT-1:0][15:0] m_out;
  logic [NOUT-1:0]       m_stb;
  logic [15:0]           m_stat;
  int unsigned           m_cnt;

  mmio_fabric dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_addr    (addr),
    .i_wr_en   (wr_en),
    .i_wr_data (wr_data),
    .o_rd_data (rd_data),
    .o_out     (out),
    .o_out_stb (out_stb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Which channel (or -1) an address selects, straight from the memory map.
  function automatic int chanOf(input logic [15:0] a);
    int off;
    if (a < 16'hFFF0) return -1;
    off = int'(a) - 32'hFFF0;
    if (off < NOUT) return off;
    if (off == 15) return 0;
    return -1;
  endfunction

  function automatic logic [15:0] modelRead(input logic [15:0] a);
    if (a < 16'd1024) return m_ram[a[9:0]];
    if (chanOf(a) >= 0) return m_out[chanOf(a)];
    if (a == 16'hFFFC) return 16'(m_cnt);
    if (a == 16'hFFFE) return m_stat;
    return 16'h0000;
  endfunction

  task automatic modelReset();
    m_out  = '0;
    m_stb  = '0;
    m_stat = 16'h0000;
    m_cnt  = 0;
  endtask

  task automatic modelEdge(input logic [15:0] a, input logic w, input logic [15:0] d);
    bit loaded;
    loaded = 1'b0;
    m_stb  = '0;
    if (w) begin
      if (a < 16'd1024) begin
        m_ram[a[9:0]] = d;
      end else if (chanOf(a) >= 0) begin
        m_out[chanOf(a)] = d;
        m_stat[chanOf(a)] = 1'b1;
        m_stb[chanOf(a)]  = 1'b1;
      end else if (a == 16'hFFFC) begin
        m_cnt  = int'(d);
        loaded = 1'b1;
      end else if (a == 16'hFFFE) begin
        m_stat = m_stat & ~(d & 16'h000F);
      end
    end
    if (!loaded) m_cnt = (m_cnt + 1) % 65536;
  endtask

  task automatic applyStimulus(input logic [15:0] a, input logic w, input logic [15:0] d);
    logic [15:0] exp_rd;
    addr    = a;
    wr_en   = w;
    wr_data = d;
    exp_rd  = modelRead(a);
    @(posedge clk);
    modelEdge(a, w, d);
    #1;
    checkOutput("rd_data", 64'(rd_data), 64'(exp_rd));
    checkOutput("out", 64'(out), 64'(m_out));
    checkOutput("out_stb", 64'(out_stb), 64'(m_stb));
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    rst     = 1'b1;
    addr    = 16'h0000;
    wr_en   = 1'b0;
    wr_data = 16'h0000;
    modelReset();
    for (int i = 0; i < 1024; i++) m_ram[i] = 16'h0000;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_out", 64'(out), 64'h0);
    checkOutput("reset_stb", 64'(out_stb), 64'h0);
    checkOutput("reset_rd", 64'(rd_data), 64'h0);
    rst = 1'b0;

    // Counter read in the fifth cycle after reset release.
    repeat (5) applyStimulus(16'h0400, 1'b0, 16'h0000);
    applyStimulus(16'hFFFC, 1'b0, 16'h0000);
    checkOutput("cnt_at_5", 64'(rd_data), 64'd5);

    // Give the exercised RAM words known contents.
    for (int i = 0; i < 32; i++) applyStimulus(16'(i), 1'b1, 16'($urandom));
    for (int i = 1008; i < 1024; i++) applyStimulus(16'(i), 1'b1, 16'($urandom));

    applyStimulus(16'hFFFE, 1'b1, 16'h000F);
    applyStimulus(16'hFFF2, 1'b1, 16'h1234);
    checkOutput("chan2", 64'(out[2]), 64'h1234);
    checkOutput("chan2_stb", 64'(out_stb), 64'b0100);
    applyStimulus(16'hFFFE, 1'b0, 16'h0000);
    checkOutput("stb_one_cycle", 64'(out_stb), 64'h0);
    checkOutput("stat_after_ch2", 64'(rd_data), 64'h0004);
    applyStimulus(16'hFFFE, 1'b1, 16'h0004);
    applyStimulus(16'hFFFE, 1'b0, 16'h0000);
    checkOutput("stat_cleared", 64'(rd_data), 64'h0000);

    applyStimulus(16'hFFFF, 1'b1, 16'hBEEF);
    checkOutput("alias_ch0", 64'(out[0]), 64'hBEEF);
    applyStimulus(16'hFFF0, 1'b0, 16'h0000);
    checkOutput("alias_read", 64'(rd_data), 64'hBEEF);
    applyStimulus(16'hFFFE, 1'b0, 16'h0000);
    checkOutput("alias_stat", 64'(rd_data), 64'h0001);

    applyStimulus(16'h0003, 1'b1, 16'h00AA);
    applyStimulus(16'h0003, 1'b0, 16'h0000);
    checkOutput("ram3", 64'(rd_data), 64'h00AA);
    applyStimulus(16'h0400, 1'b1, 16'h5555);
    applyStimulus(16'h0400, 1'b0, 16'h0000);
    checkOutput("unmapped_rd", 64'(rd_data), 64'h0000);
    applyStimulus(16'h0000, 1'b0, 16'h0000);
    checkOutput("no_alias_ram0", 64'(rd_data == 16'h5555), 64'(m_ram[0] == 16'h5555));

    applyStimulus(16'hFFFC, 1'b1, 16'hFFFE);
    applyStimulus(16'hFFFC, 1'b0, 16'h0000);
    checkOutput("cnt_fffe", 64'(rd_data), 64'hFFFE);
    applyStimulus(16'hFFFC, 1'b0, 16'h0000);
    checkOutput("cnt_ffff", 64'(rd_data), 64'hFFFF);
    applyStimulus(16'hFFFC, 1'b0, 16'h0000);
    checkOutput("cnt_wrap", 64'(rd_data), 64'h0000);

    // Back-to-back channel writes give consecutive strobes.
    applyStimulus(16'hFFF1, 1'b1, 16'h1111);
    applyStimulus(16'hFFF3, 1'b1, 16'h3333);
    checkOutput("b2b_stb", 64'(out_stb), 64'b1000);

    for (int n = 0; n < 400; n++) begin
      logic [15:0] a;
      case ($urandom_range(0, 3))
        0:       a = 16'($urandom_range(0, 31));
        1:       a = 16'hFFF0 + 16'($urandom_range(0, 15));
        2:       a = 16'($urandom_range(1008, 1023));
        default: a = 16'($urandom_range(16'h0400, 16'hFFEF));
      endcase
      applyStimulus(a, 1'($urandom_range(0, 1)), 16'($urandom));
    end

    // Reset lands between a channel write and its strobe.
    addr    = 16'hFFF1;
    wr_en   = 1'b1;
    wr_data = 16'hABCD;
    #2 rst  = 1'b1;
    #1;
    checkOutput("rst_rd_now", 64'(rd_data), 64'h0);
    checkOutput("rst_out_now", 64'(out), 64'h0);
    @(posedge clk);
    #1;
    checkOutput("rst_no_stb", 64'(out_stb), 64'h0);
    checkOutput("rst_ch1", 64'(out[1]), 64'h0);
    wr_en = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("rst_still_no_stb", 64'(out_stb), 64'h0);
    rst = 1'b0;
    modelReset();
    applyStimulus(16'hFFFE, 1'b0, 16'h0000);
    checkOutput("rst_stat", 64'(rd_data), 64'h0000);
    applyStimulus(16'hFFFC, 1'b0, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
